blob_pattern_gen: RTL and testbench

Raster stimulus source for the image-processing path. It produces a 640x480 pixel stream (`oColor`/`oDVAL`) containing one solid square "blob" centred on a programmed row/column. The stream is the input format `group_detection` consumes. It drives the detector in simulation and in on-board loopback, so coordinate-recovery accuracy can be checked without the camera.

---
 rtl/blob_pattern_gen_pkg.sv | 34 +++
 rtl/blob_pattern_gen_lfsr16.sv | 22 ++
 rtl/blob_pattern_gen.sv | 215 +++++++++++++++++++++
 tb/tb_blob_pattern_gen.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blob_pattern_gen_pkg.sv
// blob_gen_pkg: shared FSM state, pixel type, default raster size and LFSR
// constants for the blob pattern generator.
package blob_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } blob_state_t;

    typedef logic [11:0] pixel_t;

    localparam int          DEF_H_ACTIVE = 640;
    localparam int          DEF_V_ACTIVE = 480;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as state bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    // Centre value parked far outside the raster so that no blob is drawn.
    localparam logic [10:0] NO_CENTRE    = 11'h7FF;

    // Magnitude of a 12-bit signed distance; -2048 never occurs because
    // both operands of the distance are 11-bit unsigned values.
    function automatic logic [11:0] abs12(input logic signed [11:0] v);
        logic [11:0] r;
        if (v < 12'sd0) begin
            r = 12'(-v);
        end else begin
            r = 12'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/blob_pattern_gen_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR used for background speckle noise.
module lfsr16
    import blob_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    output logic [15:0] state
);

    // Shift left, feeding back the XOR of the tapped bits; hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else if (advance) begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end else begin
            state <= state;
        end
    end

endmodule

// File: rtl/blob_pattern_gen.sv
// blob_pattern_gen: raster source producing one solid square blob centred on
// a programmed row/column. Optional macro BLOB_NOISE_EN adds LFSR speckle to
// background pixels; without it the background is always 0.
module blob_pattern_gen
    import blob_gen_pkg::*;
#(
    parameter int     H_ACTIVE   = DEF_H_ACTIVE,
    parameter int     V_ACTIVE   = DEF_V_ACTIVE,
    parameter int     H_BLANK    = 16,
    parameter int     V_BLANK    = 64,
    parameter int     BLOB_HALF  = 8,
    parameter pixel_t BLOB_COLOR = 12'hF00
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [10:0] iRow,
    input  logic [10:0] iCol,
    input  logic        iLOAD,
    input  logic        iEN,
    output pixel_t      oColor,
    output logic        oDVAL,
    output logic        oFRAME_START,
    output logic        oBUSY
);

    localparam logic [10:0] COL_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] ROW_LAST = 11'(V_ACTIVE - 1);
    localparam logic [15:0] HB_LAST  = (H_BLANK > 0) ? 16'(H_BLANK - 1) : 16'd0;
    localparam logic [15:0] VB_LAST  = (V_BLANK > 0) ? 16'(V_BLANK - 1) : 16'd0;
    localparam logic [11:0] HALF12   = 12'(BLOB_HALF);

    blob_state_t        state_r;
    blob_state_t        eof_state_s;
    blob_state_t        vb_exit_state_s;
    logic [10:0]        row_r;
    logic [10:0]        col_r;
    logic [10:0]        shadow_row_r;
    logic [10:0]        shadow_col_r;
    logic [10:0]        cy_r;
    logic [10:0]        cx_r;
    logic [10:0]        cy_s;
    logic [10:0]        cx_s;
    logic [15:0]        blank_cnt_r;
    logic               frame_start_s;
    logic               last_col_s;
    logic               last_row_s;
    logic               in_blob_s;
    logic               noise_s;
    logic signed [11:0] dr_s;
    logic signed [11:0] dc_s;
    pixel_t             pix_s;

`ifdef BLOB_NOISE_EN
    logic [15:0] lfsr_state_s;
    logic        lfsr_advance_s;

    assign lfsr_advance_s = (state_r == ST_ACTIVE);
    assign noise_s        = (lfsr_state_s[7:0] == 8'h00);

    lfsr16 u_lfsr16 (
        .clk     (iCLK),
        .rst     (iRST),
        .advance (lfsr_advance_s),
        .state   (lfsr_state_s)
    );
`else
    assign noise_s = 1'b0;
`endif

    // Pixel (0,0) is where the shadow centre becomes the frame's centre; a
    // load on that same cycle bypasses the shadow so it lands in this frame.
    always_comb begin
        frame_start_s = (state_r == ST_ACTIVE) && (row_r == 11'd0) && (col_r == 11'd0);
        last_col_s    = (col_r == COL_LAST);
        last_row_s    = (row_r == ROW_LAST);
        if (frame_start_s) begin
            if (iLOAD) begin
                cy_s = iRow;
                cx_s = iCol;
            end else begin
                cy_s = shadow_row_r;
                cx_s = shadow_col_r;
            end
        end else begin
            cy_s = cy_r;
            cx_s = cx_r;
        end
    end

    // Blob membership in 12-bit signed distance so centres near 0 clip cleanly.
    always_comb begin
        dr_s      = $signed({1'b0, row_r}) - $signed({1'b0, cy_s});
        dc_s      = $signed({1'b0, col_r}) - $signed({1'b0, cx_s});
        in_blob_s = (abs12(dr_s) <= HALF12) && (abs12(dc_s) <= HALF12);
        if (in_blob_s || noise_s) begin
            pix_s = BLOB_COLOR;
        end else begin
            pix_s = 12'h000;
        end
    end

    // Where the FSM goes once a frame's active area (and last HBLANK) is done.
    always_comb begin
        if (iEN) begin
            vb_exit_state_s = ST_ACTIVE;
        end else begin
            vb_exit_state_s = ST_IDLE;
        end
        if (V_BLANK != 0) begin
            eof_state_s = ST_VBLANK;
        end else begin
            eof_state_s = vb_exit_state_s;
        end
    end

    // Raster FSM with counters, centre capture and registered pixel outputs.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_r      <= ST_IDLE;
            row_r        <= 11'd0;
            col_r        <= 11'd0;
            blank_cnt_r  <= 16'd0;
            shadow_row_r <= NO_CENTRE;
            shadow_col_r <= NO_CENTRE;
            cy_r         <= NO_CENTRE;
            cx_r         <= NO_CENTRE;
            oColor       <= 12'h000;
            oDVAL        <= 1'b0;
            oFRAME_START <= 1'b0;
            oBUSY        <= 1'b0;
        end else begin
            if (iLOAD) begin
                shadow_row_r <= iRow;
                shadow_col_r <= iCol;
            end
            oColor       <= 12'h000;
            oDVAL        <= 1'b0;
            oFRAME_START <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (iEN) begin
                        state_r <= ST_ACTIVE;
                        row_r   <= 11'd0;
                        col_r   <= 11'd0;
                        oBUSY   <= 1'b1;
                    end else begin
                        oBUSY   <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    oColor       <= pix_s;
                    oDVAL        <= 1'b1;
                    oFRAME_START <= frame_start_s;
                    oBUSY        <= 1'b1;
                    if (frame_start_s) begin
                        cy_r <= cy_s;
                        cx_r <= cx_s;
                    end
                    if (last_col_s) begin
                        col_r <= 11'd0;
                        if (last_row_s) begin
                            row_r <= 11'd0;
                        end else begin
                            row_r <= row_r + 11'd1;
                        end
                        // The last row also gets its HBLANK before VBLANK,
                        // keeping every row H_ACTIVE+H_BLANK cycles long.
                        if (H_BLANK != 0) begin
                            state_r     <= ST_HBLANK;
                            blank_cnt_r <= 16'd0;
                        end else if (last_row_s) begin
                            state_r     <= eof_state_s;
                            blank_cnt_r <= 16'd0;
                            oBUSY       <= (eof_state_s != ST_IDLE);
                        end else begin
                            state_r     <= ST_ACTIVE;
                        end
                    end else begin
                        col_r <= col_r + 11'd1;
                    end
                end
                ST_HBLANK: begin
                    oBUSY <= 1'b1;
                    if (blank_cnt_r == HB_LAST) begin
                        blank_cnt_r <= 16'd0;
                        // Row counter already wrapped to 0 means the frame ended.
                        if (row_r == 11'd0) begin
                            state_r <= eof_state_s;
                            oBUSY   <= (eof_state_s != ST_IDLE);
                        end else begin
                            state_r <= ST_ACTIVE;
                        end
                    end else begin
                        blank_cnt_r <= blank_cnt_r + 16'd1;
                    end
                end
                ST_VBLANK: begin
                    if (blank_cnt_r == VB_LAST) begin
                        blank_cnt_r <= 16'd0;
                        state_r     <= vb_exit_state_s;
                        oBUSY       <= (vb_exit_state_s != ST_IDLE);
                    end else begin
                        blank_cnt_r <= blank_cnt_r + 16'd1;
                        oBUSY       <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    oBUSY   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blob_pattern_gen.sv
// Self-checking bench for blob_pattern_gen using a reduced raster so whole
// frames fit in a short run. A second instance with zero blanking checks
// that the pixel stream is gap-free across frames.
module tb_blob_pattern_gen;

    localparam int          P_H       = 24;
    localparam int          P_V       = 16;
    localparam int          P_HB      = 3;
    localparam int          P_VB      = 5;
    localparam int          P_HALF    = 2;
    localparam logic [11:0] P_COLOR   = 12'hF00;
    localparam int          NPIX      = P_H * P_V;
    localparam int          FRAME_LEN = P_V * (P_H + P_HB) + P_VB;
    localparam int          FAR       = 2047;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        en;
    logic [10:0] row_in;
    logic [10:0] col_in;
    logic [11:0] color;
    logic        dval;
    logic        fs;
    logic        busy;
    logic [11:0] color0;
    logic        dval0;
    logic        fs0;
    logic        busy0;

    int total = 0;
    int bad   = 0;

`ifdef BLOB_NOISE_EN
    logic [15:0] lfsr_m;
`endif

    always #5 clk = ~clk;

    blob_pattern_gen #(
        .H_ACTIVE(P_H), .V_ACTIVE(P_V), .H_BLANK(P_HB), .V_BLANK(P_VB),
        .BLOB_HALF(P_HALF), .BLOB_COLOR(P_COLOR)
    ) dut (
        .iCLK(clk), .iRST(rst), .iRow(row_in), .iCol(col_in), .iLOAD(load),
        .iEN(en), .oColor(color), .oDVAL(dval), .oFRAME_START(fs), .oBUSY(busy)
    );

    blob_pattern_gen #(
        .H_ACTIVE(P_H), .V_ACTIVE(P_V), .H_BLANK(0), .V_BLANK(0),
        .BLOB_HALF(P_HALF), .BLOB_COLOR(P_COLOR)
    ) dut0 (
        .iCLK(clk), .iRST(rst), .iRow(row_in), .iCol(col_in), .iLOAD(load),
        .iEN(en), .oColor(color0), .oDVAL(dval0), .oFRAME_START(fs0), .oBUSY(busy0)
    );

    // Reference pixel: inside the square around (cy,cx) or a noise hit.
    function automatic logic [11:0] expect_pix(input int r, input int c,
                                               input int cy, input int cx,
                                               input logic noise);
        int dr;
        int dc;
        dr = r - cy;
        dc = c - cx;
        if (dr < 0) dr = -dr;
        if (dc < 0) dc = -dc;
        if (dr <= P_HALF && dc <= P_HALF) return P_COLOR;
        if (noise) return P_COLOR;
        return 12'h000;
    endfunction

    task automatic load_centre(input int r, input int c);
        row_in = 11'(r);
        col_in = 11'(c);
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    // Capture one frame and compare every pixel against the reference.
    task automatic run_frame(input int cy, input int cx, input bit started,
                             input int load_at, input int lr, input int lc,
                             input string tag, output int span);
        int          idx;
        int          errs;
        int          cyc;
        int          fr;
        int          fc;
        logic [11:0] e;
        logic [11:0] fgot;
        logic [11:0] fexp;
        logic        nz;
        idx  = 0;
        errs = 0;
        cyc  = 0;
        fr   = -1;
        fc   = -1;
        fgot = 12'h000;
        fexp = 12'h000;
        span = 0;
        if (!started) begin
            while (fs !== 1'b1 && cyc < 2 * FRAME_LEN) begin
                @(negedge clk);
                cyc++;
            end
            total++;
            if (fs !== 1'b1) begin
                bad++;
                $display("FAIL %s_start: got no frame start, want one within %0d cycles", tag, 2 * FRAME_LEN);
                return;
            end
        end
        cyc = 0;
        while (idx < NPIX && cyc < 2 * FRAME_LEN) begin
            if (load) load = 1'b0;
            if (dval === 1'b1) begin
`ifdef BLOB_NOISE_EN
                nz     = (lfsr_m[7:0] == 8'h00);
                lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`else
                nz     = 1'b0;
`endif
                e = expect_pix(idx / P_H, idx % P_H, cy, cx, nz);
                if (color !== e || fs !== (idx == 0)) begin
                    if (errs == 0) begin
                        fr   = idx / P_H;
                        fc   = idx % P_H;
                        fgot = color;
                        fexp = e;
                    end
                    errs++;
                end
                idx++;
                if (idx == load_at) begin
                    row_in = 11'(lr);
                    col_in = 11'(lc);
                    load   = 1'b1;
                end
            end
            if (idx < NPIX) begin
                @(negedge clk);
                cyc++;
            end
        end
        load = 1'b0;
        span = cyc;
        total++;
        if (idx != NPIX) begin
            bad++;
            $display("FAIL %s_count: got %0d valid pixels, want %0d", tag, idx, NPIX);
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s_pixels: %0d wrong, first at (%0d,%0d) got %h want %h",
                     tag, errs, fr, fc, fgot, fexp);
        end
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        en     = 1'b0;
        load   = 1'b0;
        row_in = 11'd0;
        col_in = 11'd0;
        repeat (3) @(negedge clk);
        total++;
        if ({color, dval, fs, busy, color0, dval0, fs0, busy0} !== 30'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h/%b/%b/%b, want 000/0/0/0", color, dval, fs, busy);
        end
        rst = 1'b0;
`ifdef BLOB_NOISE_EN
        lfsr_m = 16'hACE1;
`endif
        repeat (5) @(negedge clk);
        total++;
        if (dval !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got dval=%b busy=%b, want 0/0", dval, busy);
        end
    endtask

    // iEN rises; load coincides with the (0,0) cycle and must apply at once.
    task automatic test_start_latency;
        int span;
        en = 1'b1;
        @(negedge clk);
        total++;
        if (dval !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL latency_first: got dval=%b busy=%b, want 0/1", dval, busy);
        end
        row_in = 11'd3;
        col_in = 11'd4;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        total++;
        if (dval !== 1'b1 || fs !== 1'b1) begin
            bad++;
            $display("FAIL latency_second: got dval=%b fs=%b, want 1/1", dval, fs);
        end
        run_frame(3, 4, 1'b1, -1, 0, 0, "first", span);
    endtask

    task automatic test_normal;
        int span;
        load_centre(8, 12);
        run_frame(8, 12, 1'b0, -1, 0, 0, "normal", span);
    endtask

    task automatic test_clip;
        int span;
        load_centre(0, 0);
        run_frame(0, 0, 1'b0, -1, 0, 0, "corner", span);
        load_centre(P_V + 1, P_H + 1);
        run_frame(P_V + 1, P_H + 1, 1'b0, -1, 0, 0, "far_edge", span);
        load_centre(P_V + 3, P_H + 3);
        run_frame(P_V + 3, P_H + 3, 1'b0, -1, 0, 0, "no_blob", span);
    endtask

    task automatic test_random;
        int span;
        int r;
        int c;
        for (int k = 0; k < 3; k++) begin
            r = int'($urandom_range(0, P_V + 3));
            c = int'($urandom_range(0, P_H + 3));
            load_centre(r, c);
            run_frame(r, c, 1'b0, -1, 0, 0, "random", span);
        end
        load_centre(9, 9);
        run_frame(9, 9, 1'b0, -1, 0, 0, "pre_mid", span);
    endtask

    // Load mid-frame: current frame keeps (9,9), next frame moves to (5,7).
    task automatic test_midframe_load;
        int span;
        run_frame(9, 9, 1'b0, 100, 5, 7, "mid_old", span);
        run_frame(5, 7, 1'b0, -1, 0, 0, "mid_new", span);
    endtask

    task automatic test_back_to_back;
        load_centre(10, 20);
        fork
            begin
                int span;
                int gap;
                run_frame(10, 20, 1'b0, -1, 0, 0, "b2b_a", span);
                gap = 0;
                while (fs !== 1'b1 && gap < 2 * FRAME_LEN) begin
                    @(negedge clk);
                    gap++;
                end
                total++;
                if (span + gap != FRAME_LEN) begin
                    bad++;
                    $display("FAIL frame_length: got %0d cycles, want %0d", span + gap, FRAME_LEN);
                end
                run_frame(10, 20, 1'b1, -1, 0, 0, "b2b_b", span);
            end
            begin
                int cyc;
                int low;
                int fsn;
                cyc = 0;
                low = 0;
                fsn = 0;
                while (fs0 !== 1'b1 && cyc < 2 * NPIX) begin
                    @(negedge clk);
                    cyc++;
                end
                for (int i = 0; i < 2 * NPIX; i++) begin
                    if (dval0 !== 1'b1) low++;
                    if (fs0 === 1'b1) fsn++;
                    @(negedge clk);
                end
                total++;
                if (low != 0) begin
                    bad++;
                    $display("FAIL noblank_gaps: got %0d idle cycles, want 0", low);
                end
                total++;
                if (fsn != 2) begin
                    bad++;
                    $display("FAIL noblank_starts: got %0d frame starts, want 2", fsn);
                end
            end
        join
    endtask

    task automatic test_reset_midframe;
        int cyc;
        int quiet;
        int span;
        cyc = 0;
        while (fs !== 1'b1 && cyc < 2 * FRAME_LEN) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5 * (P_H + P_HB) + 7) @(negedge clk);
        total++;
        if (dval !== 1'b1) begin
            bad++;
            $display("FAIL midreset_streaming: got dval=%b, want 1", dval);
        end
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        total++;
        if ({color, dval, fs, busy} !== 15'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got %h/%b/%b/%b, want 000/0/0/0", color, dval, fs, busy);
        end
        rst = 1'b0;
`ifdef BLOB_NOISE_EN
        lfsr_m = 16'hACE1;
`endif
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (dval !== 1'b0 || busy !== 1'b0) quiet++;
        end
        total++;
        if (quiet != 0) begin
            bad++;
            $display("FAIL midreset_quiet: got %0d active cycles, want 0", quiet);
        end
        en = 1'b1;
        run_frame(FAR, FAR, 1'b0, -1, 0, 0, "after_reset", span);
    endtask

    // Drop iEN at pixel (0,0): frame must complete, then blanking, then idle.
    task automatic test_stop;
        int cyc;
        int span;
        int dv;
        cyc = 0;
        while (fs !== 1'b1 && cyc < 2 * FRAME_LEN) begin
            @(negedge clk);
            cyc++;
        end
        en = 1'b0;
        run_frame(FAR, FAR, 1'b1, -1, 0, 0, "stop_frame", span);
        cyc = 0;
        dv  = 0;
        while (busy !== 1'b0 && cyc < 4 * (P_HB + P_VB)) begin
            @(negedge clk);
            cyc++;
            if (dval !== 1'b0) dv++;
        end
        total++;
        if (cyc != P_HB + P_VB || dv != 0) begin
            bad++;
            $display("FAIL stop_tail: got %0d cycles (%0d valid), want %0d (0)", cyc, dv, P_HB + P_VB);
        end
        dv = 0;
        repeat (50) begin
            @(negedge clk);
            if (dval !== 1'b0 || busy !== 1'b0) dv++;
        end
        total++;
        if (dv != 0) begin
            bad++;
            $display("FAIL stop_idle: got %0d active cycles, want 0", dv);
        end
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        load   = 1'b0;
        row_in = 11'd0;
        col_in = 11'd0;
        test_reset();
        test_start_latency();
        test_normal();
        test_clip();
        test_random();
        test_midframe_load();
        test_back_to_back();
        test_reset_midframe();
        test_stop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
